// File: rtl/decoder_scan_seq_pkg.sv
// Shared types for the one-hot decoder / round-robin scan sequencer.
// Mode and FSM state enums plus the select-to-output width helper.
package decoder_pkg;

    typedef enum logic {
        DEC_MODE_DIRECT = 1'b0,
        DEC_MODE_SCAN   = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } dec_state_e;

    function automatic int out_width(input int sel_w);
        return 1 << sel_w;
    endfunction

endpackage

// File: rtl/decoder_scan_seq_if.sv
// Handshake/control bundle between a select source and decoder_scan_seq.
// Optional parity pins appear when DECODER_SCAN_PARITY_EN is defined.
interface decoder_scan_seq_if #(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 4
);
    import decoder_pkg::*;

    localparam int OUT_W = out_width(SEL_W);

    logic               enable;
    mode_e              mode;
    logic               sel_valid;
    logic [SEL_W-1:0]   sel;
    logic               sel_ready;
    logic [DWELL_W-1:0] dwell;
    logic [OUT_W-1:0]   y;
    logic               y_valid;
    logic               wrap;
`ifdef DECODER_SCAN_PARITY_EN
    logic               sel_par;
    logic               par_err;
`endif

    modport master (
`ifdef DECODER_SCAN_PARITY_EN
        output sel_par,
        input  par_err,
`endif
        output enable, mode, sel_valid, sel, dwell,
        input  sel_ready, y, y_valid, wrap
    );

    modport slave (
`ifdef DECODER_SCAN_PARITY_EN
        input  sel_par,
        output par_err,
`endif
        input  enable, mode, sel_valid, sel, dwell,
        output sel_ready, y, y_valid, wrap
    );

endinterface

// File: rtl/decoder_scan_seq_onehot_dec.sv
// Combinational binary-index to one-hot decoder shared by both modes.
module onehot_dec #(
    parameter int SEL_W = 2
) (
    input  logic [SEL_W-1:0]      i_idx,
    output logic [(1<<SEL_W)-1:0] o_onehot
);

    always_comb begin
        o_onehot        = '0;
        o_onehot[i_idx] = 1'b1;
    end

endmodule

// File: rtl/decoder_scan_seq.sv
// Registered one-hot decoder with DIRECT (handshaked select) and SCAN (dwell-timed
// round-robin) modes. Define DECODER_SCAN_PARITY_EN to add select parity checking.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | disabled; outputs off, scan position cleared
//   ST_DIRECT | decode accepted select, hold value until next accept
//   ST_SCAN   | walk outputs 0..OUT_W-1, dwell+1 cycles per position
module decoder_scan_seq
    import decoder_pkg::*;
#(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    decoder_scan_seq_if.slave bus
);

    localparam int OUT_W = out_width(SEL_W);
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(OUT_W - 1);

    dec_state_e         r_state;
    logic [SEL_W-1:0]   r_idx;
    logic [DWELL_W-1:0] r_dcnt;
    logic [OUT_W-1:0]   r_y;
    logic               r_y_valid;
    logic               r_wrap;

    logic               w_accept;
    logic               w_scan_entry;
    logic               w_step;
    logic               w_par_ok;
    logic [SEL_W-1:0]   w_idx_nxt;
    logic [SEL_W-1:0]   w_dec_in;
    logic [OUT_W-1:0]   w_onehot;

    assign bus.sel_ready = bus.enable && (bus.mode == DEC_MODE_DIRECT);
    assign w_accept      = bus.sel_valid && bus.sel_ready;

    // Entering SCAN always restarts at index 0; afterwards step when the
    // dwell counter reaches the live dwell value.
    assign w_scan_entry = (r_state != ST_SCAN);
    assign w_step       = (r_dcnt >= bus.dwell);
    assign w_idx_nxt    = w_scan_entry ? '0 : (w_step ? r_idx + 1'b1 : r_idx);
    assign w_dec_in     = (bus.mode == DEC_MODE_SCAN) ? w_idx_nxt : bus.sel;

    onehot_dec #(.SEL_W(SEL_W)) u_onehot_dec (
        .i_idx    (w_dec_in),
        .o_onehot (w_onehot)
    );

`ifdef DECODER_SCAN_PARITY_EN
    logic r_par_err;
    assign w_par_ok    = ~^{bus.sel, bus.sel_par};
    assign bus.par_err = r_par_err;
`else
    assign w_par_ok    = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_dcnt    <= '0;
            r_y       <= '0;
            r_y_valid <= 1'b0;
            r_wrap    <= 1'b0;
`ifdef DECODER_SCAN_PARITY_EN
            r_par_err <= 1'b0;
`endif
        end else begin
            r_wrap <= 1'b0;
`ifdef DECODER_SCAN_PARITY_EN
            r_par_err <= 1'b0;
`endif
            if (!bus.enable) begin
                r_state   <= ST_IDLE;
                r_idx     <= '0;
                r_dcnt    <= '0;
                r_y       <= '0;
                r_y_valid <= 1'b0;
            end else if (bus.mode == DEC_MODE_DIRECT) begin
                r_state <= ST_DIRECT;
                r_idx   <= '0;
                r_dcnt  <= '0;
                if (w_accept && w_par_ok) begin
                    r_y       <= w_onehot;
                    r_y_valid <= 1'b1;
                end else if (r_state != ST_DIRECT) begin
                    r_y       <= '0;
                    r_y_valid <= 1'b0;
                end
`ifdef DECODER_SCAN_PARITY_EN
                // A bad-parity select is consumed but never reaches y.
                if (w_accept && !w_par_ok) begin
                    r_par_err <= 1'b1;
                end
`endif
            end else begin
                r_state   <= ST_SCAN;
                r_idx     <= w_idx_nxt;
                r_y       <= w_onehot;
                r_y_valid <= 1'b1;
                if (w_scan_entry || w_step) begin
                    r_dcnt <= '0;
                end else begin
                    r_dcnt <= r_dcnt + 1'b1;
                end
                r_wrap <= !w_scan_entry && w_step && (r_idx == IDX_LAST);
            end
        end
    end

    assign bus.y       = r_y;
    assign bus.y_valid = r_y_valid;
    assign bus.wrap    = r_wrap;

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Directed bench for decoder_scan_seq: arithmetic reference model checked every
// cycle, plus literal expectations for the key DIRECT/SCAN/reset scenarios.
module tb_decoder_scan_seq;
    import decoder_pkg::*;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    decoder_scan_seq_if #(.SEL_W(2), .DWELL_W(4)) bus ();

    decoder_scan_seq #(.SEL_W(2), .DWELL_W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit cmp_on = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: segment bookkeeping plus arithmetic on cycles since SCAN entry.
    int         m_seg  = 0;   // 0 off, 1 direct, 2 scan
    int         m_last = -1;
    int         m_k    = 0;
    int         m_dw   = 0;
    int         m_step;
    logic       m_bad;
    logic [3:0] e_y    = '0;
    logic       e_v    = 1'b0;
    logic       e_w    = 1'b0;
    logic       e_perr = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_seg = 0; m_last = -1; m_k = 0;
            e_y = '0; e_v = 1'b0; e_w = 1'b0; e_perr = 1'b0;
        end else if (!bus.enable) begin
            m_seg = 0;
            e_y = '0; e_v = 1'b0; e_w = 1'b0; e_perr = 1'b0;
        end else if (bus.mode == DEC_MODE_DIRECT) begin
            if (m_seg != 1) begin
                m_seg  = 1;
                m_last = -1;
            end
            m_bad  = 1'b0;
`ifdef DECODER_SCAN_PARITY_EN
            m_bad  = ^{bus.sel, bus.sel_par};
`endif
            e_perr = 1'b0;
            if (bus.sel_valid) begin
                if (m_bad) e_perr = 1'b1;
                else       m_last = int'(bus.sel);
            end
            e_v = (m_last >= 0);
            e_y = e_v ? 4'(1 << m_last) : 4'd0;
            e_w = 1'b0;
        end else begin
            if (m_seg != 2) begin
                m_seg = 2;
                m_k   = 0;
                m_dw  = int'(bus.dwell);
            end else begin
                m_k++;
            end
            m_step = m_k / (m_dw + 1);
            e_y    = 4'(1 << (m_step % 4));
            e_v    = 1'b1;
            e_w    = (m_k > 0) && (m_k % (m_dw + 1) == 0) && (m_step % 4 == 0);
            e_perr = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("model_y", bus.y, e_y);
            chk("model_y_valid", bus.y_valid, e_v);
            chk("model_wrap", bus.wrap, e_w);
            chk("sel_ready", bus.sel_ready, bus.enable && (bus.mode == DEC_MODE_DIRECT));
            chk("onehot_invariant", bus.y_valid ? $onehot(bus.y) : (bus.y == 4'd0), 1'b1);
`ifdef DECODER_SCAN_PARITY_EN
            chk("model_par_err", bus.par_err, e_perr);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sel(input logic [1:0] s);
        bus.sel = s;
`ifdef DECODER_SCAN_PARITY_EN
        bus.sel_par = ^s;
`endif
    endtask

    logic [3:0] scan2_tab [13] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010,
                                   4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b1000,
                                   4'b0001};
    logic [3:0] scan0_tab [9]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001,
                                   4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int wraps;

    initial begin
        bus.enable    = 1'b0;
        bus.mode      = DEC_MODE_DIRECT;
        bus.sel_valid = 1'b0;
        bus.dwell     = '0;
        set_sel(2'd0);

        tick();
        tick();
        chk("reset_y", bus.y, 4'd0);
        chk("reset_y_valid", bus.y_valid, 1'b0);
        chk("reset_wrap", bus.wrap, 1'b0);
        reset_n = 1'b1;
        tick();

        // DIRECT: single accept then back-to-back accepts
        bus.enable = 1'b1; bus.mode = DEC_MODE_DIRECT;
        bus.sel_valid = 1'b1; set_sel(2'd2);
        tick();
        chk("direct_sel2_y", bus.y, 4'b0100);
        chk("direct_sel2_valid", bus.y_valid, 1'b1);
        set_sel(2'd3);
        tick();
        chk("direct_b2b_sel3", bus.y, 4'b1000);
        set_sel(2'd0);
        tick();
        chk("direct_b2b_sel0", bus.y, 4'b0001);
        bus.sel_valid = 1'b0; set_sel(2'd2);
        tick();
        chk("direct_hold", bus.y, 4'b0001);

        // enable drop with a select pending: no accept, outputs off
        bus.enable = 1'b0; bus.sel_valid = 1'b1; set_sel(2'd1);
        #1;
        chk("disabled_sel_ready", bus.sel_ready, 1'b0);
        tick();
        chk("disabled_y", bus.y, 4'd0);
        chk("disabled_valid", bus.y_valid, 1'b0);
        bus.enable = 1'b1; bus.sel_valid = 1'b0;
        tick();
        chk("reenable_y", bus.y, 4'd0);
        tick();
        chk("reenable_valid", bus.y_valid, 1'b0);
        bus.sel_valid = 1'b1; set_sel(2'd1);
        tick();
        chk("reenable_accept", bus.y, 4'b0010);

`ifdef DECODER_SCAN_PARITY_EN
        set_sel(2'd3);
        tick();
        chk("par_good_sel3", bus.y, 4'b1000);
        bus.sel = 2'd1; bus.sel_par = 1'b0;
        tick();
        chk("par_bad_y_held", bus.y, 4'b1000);
        chk("par_bad_err", bus.par_err, 1'b1);
        bus.sel = 2'd1; bus.sel_par = 1'b1;
        tick();
        chk("par_good_y", bus.y, 4'b0010);
        chk("par_good_err", bus.par_err, 1'b0);
`endif
        bus.sel_valid = 1'b0;

        // SCAN, dwell=2: three cycles per position, wrap on return to bit 0
        bus.mode = DEC_MODE_SCAN; bus.dwell = 4'd2;
        for (int i = 0; i < 13; i++) begin
            tick();
            chk("scan_dwell2_y", bus.y, scan2_tab[i]);
            chk("scan_dwell2_wrap", bus.wrap, (i == 12) ? 1'b1 : 1'b0);
        end

        // Switch to DIRECT mid-scan: outputs clear next cycle
        bus.mode = DEC_MODE_DIRECT;
        tick();
        chk("scan_to_direct_y", bus.y, 4'd0);
        chk("scan_to_direct_valid", bus.y_valid, 1'b0);

        // SCAN, dwell=0: new bit every cycle, wrap every 4 cycles
        bus.mode = DEC_MODE_SCAN; bus.dwell = 4'd0;
        wraps = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("scan_dwell0_y", bus.y, scan0_tab[i]);
            if (bus.wrap) wraps++;
        end
        chk("scan_dwell0_wrap_now", bus.wrap, 1'b1);
        chk("scan_dwell0_wrap_count", wraps, 2);

        // Async reset with wrap high: outputs clear without a clock edge
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_y", bus.y, 4'd0);
        chk("async_reset_valid", bus.y_valid, 1'b0);
        chk("async_reset_wrap", bus.wrap, 1'b0);
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        chk("post_reset_scan_restart", bus.y, 4'b0010);

        cmp_on = 1'b0;
        tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
